// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between a CPU (read plus posted
// writes through a 1-entry write buffer) and a video read port.
// The arbiter issues RAM accesses only from IDLE. Read data comes back one
// cycle later and is acknowledged from CPU_RD or VID_RD.
// A starvation counter forces a pending video read to win after
// VID_MAX_WAIT consecutive losses.
// Optional build macro MEM_ARB_WP_EN enables write protection. With it,
// CPU writes below 0x200 are discarded and pulse wp_hit.
module mem_arbiter #(
  parameter int VID_MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic [11:0] cpu_read_addr,
  output logic [7:0]  cpu_read_data,
  output logic        cpu_read_ack,
  input  logic        cpu_write,
  input  logic [11:0] cpu_write_addr,
  input  logic [7:0]  cpu_write_data,
  input  logic        vid_read,
  input  logic [11:0] vid_read_addr,
  output logic [7:0]  vid_read_data,
  output logic        vid_read_ack,
  output logic        ram_en,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        wr_overflow,
  output logic        wp_hit
);

  localparam int CW = (VID_MAX_WAIT < 1) ? 1 : $clog2(VID_MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(VID_MAX_WAIT);

  typedef enum logic [1:0] {IDLE, CPU_RD, VID_RD} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          wb_valid;
  logic [11:0]   wb_addr;
  logic [7:0]    wb_data;
  logic [7:0]    cpu_data_q;
  logic [7:0]    vid_data_q;

  logic          idle_issue;
  logic          grant_wr;
  logic          grant_cpu;
  logic          grant_vid;
  logic          wr_protected;
  logic          wr_accept;
  logic          wr_drop;

  // Arbitration: buffered write first, then CPU, unless the video port has
  // lost VID_MAX_WAIT times in a row.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned and a latch is never inferred.
    idle_issue = (state == IDLE) && !rst;
    grant_wr   = 1'b0;
    grant_cpu  = 1'b0;
    grant_vid  = 1'b0;
    if (idle_issue) begin
      if (wb_valid) begin
        grant_wr = 1'b1;
      end else if (vid_read && (!cpu_read || starve_cnt == WAIT_MAX)) begin
        grant_vid = 1'b1;
      end else if (cpu_read) begin
        grant_cpu = 1'b1;
      end
    end
`ifdef MEM_ARB_WP_EN
    wr_protected = (cpu_write_addr < 12'h200);
`else
    wr_protected = 1'b0;
`endif
    // A slot frees up in the same edge the buffer drains, so a write
    // arriving then is still taken.
    wr_accept = cpu_write && !wr_protected && (!wb_valid || grant_wr);
    wr_drop   = cpu_write && !wr_protected && wb_valid && !grant_wr;
  end

  // RAM port: driven only while IDLE grants an access.
  always_comb begin
    ram_en    = grant_wr || grant_cpu || grant_vid;
    ram_we    = grant_wr;
    ram_wdata = wb_data;
    ram_addr  = '0;
    if (grant_wr) begin
      ram_addr = wb_addr;
    end else if (grant_cpu) begin
      ram_addr = cpu_read_addr;
    end else if (grant_vid) begin
      ram_addr = vid_read_addr;
    end
  end

  // Acks come straight from the registered state. RAM data passes through
  // during the ack cycle and is held afterwards.
  always_comb begin
    cpu_read_ack  = (state == CPU_RD);
    vid_read_ack  = (state == VID_RD);
    cpu_read_data = cpu_read_ack ? ram_rdata : cpu_data_q;
    vid_read_data = vid_read_ack ? ram_rdata : vid_data_q;
  end

  // FSM, starvation counter and held read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      cpu_data_q <= '0;
      vid_data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            state <= CPU_RD;
          end else if (grant_vid) begin
            state <= VID_RD;
          end
          if (!vid_read || grant_vid) begin
            starve_cnt <= '0;
          end else if (starve_cnt != WAIT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        CPU_RD: begin
          cpu_data_q <= ram_rdata;
          state      <= IDLE;
        end
        VID_RD: begin
          vid_data_q <= ram_rdata;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write buffer valid flag and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wb_valid <= 1'b1;
      end else if (grant_wr) begin
        wb_valid <= 1'b0;
      end
      if (wr_drop) begin
        wr_overflow <= 1'b1;
      end
    end
  end

  // Write buffer payload, loaded together with the valid flag.
  // NOTE: payload registers carry no reset; wb_valid alone says whether
  // their contents mean anything.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wb_addr <= cpu_write_addr;
      wb_data <= cpu_write_data;
    end
  end

`ifdef MEM_ARB_WP_EN
  logic wp_hit_q;

  // One-cycle pulse for each discarded protected write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_hit_q <= 1'b0;
    end else begin
      wp_hit_q <= cpu_write && wr_protected;
    end
  end

  assign wp_hit = wp_hit_q;
`else
  assign wp_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. It runs a per-cycle table of inputs and
// expected outputs against a behavioural RAM, then hand-written sequences
// for reset during a video read and for write protection (MEM_ARB_WP_EN).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_read = 1'b0;
  logic [11:0] cpu_read_addr = '0;
  logic [7:0]  cpu_read_data;
  logic        cpu_read_ack;
  logic        cpu_write = 1'b0;
  logic [11:0] cpu_write_addr = '0;
  logic [7:0]  cpu_write_data = '0;
  logic        vid_read = 1'b0;
  logic [11:0] vid_read_addr = '0;
  logic [7:0]  vid_read_data;
  logic        vid_read_ack;
  logic        ram_en;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        wr_overflow;
  logic        wp_hit;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.VID_MAX_WAIT(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_read_addr(cpu_read_addr),
    .cpu_read_data(cpu_read_data), .cpu_read_ack(cpu_read_ack),
    .cpu_write(cpu_write), .cpu_write_addr(cpu_write_addr),
    .cpu_write_data(cpu_write_data),
    .vid_read(vid_read), .vid_read_addr(vid_read_addr),
    .vid_read_data(vid_read_data), .vid_read_ack(vid_read_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr_overflow(wr_overflow), .wp_hit(wp_hit)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM, preloaded while rst is high.
  logic [7:0] ram [4096];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h050] <= 8'h33;
      ram[12'h200] <= 8'hA2;
      ram[12'h400] <= 8'h11;
      ram[12'h500] <= 8'h22;
      ram[12'h700] <= 8'h07;
      ram_rdata    <= 8'h00;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        crd;
    logic [11:0] cra;
    logic        cwr;
    logic [11:0] cwa;
    logic [7:0]  cwd;
    logic        vrd;
    logic [11:0] vra;
    logic        en;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wd;
    logic        ca;
    logic [7:0]  cd;
    logic        va;
    logic [7:0]  vd;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic crd, input logic [11:0] cra,
    input logic cwr, input logic [11:0] cwa, input logic [7:0] cwd,
    input logic vrd, input logic [11:0] vra,
    input logic en, input logic we, input logic [11:0] addr, input logic [7:0] wd,
    input logic ca, input logic [7:0] cd, input logic va, input logic [7:0] vd,
    input logic ovf);
    return '{crd, cra, cwr, cwa, cwd, vrd, vra, en, we, addr, wd, ca, cd, va, vd, ovf};
  endfunction

  task automatic check_idle_outputs(input string tag, input logic [7:0] cd,
                                    input logic [7:0] vd, input logic ovf);
    check({tag, "_en"},   ram_en, 1'b0);
    check({tag, "_we"},   ram_we, 1'b0);
    check({tag, "_cack"}, cpu_read_ack, 1'b0);
    check({tag, "_vack"}, vid_read_ack, 1'b0);
    check({tag, "_cdat"}, cpu_read_data, cd);
    check({tag, "_vdat"}, vid_read_data, vd);
    check({tag, "_ovf"},  wr_overflow, ovf);
    check({tag, "_wp"},   wp_hit, 1'b0);
  endtask

  initial begin
    // Per cycle: cpu rd(addr), cpu wr(addr,data), vid rd(addr)
    //            | en we addr wdata | cack cdata | vack vdata | ovf
    // Single CPU read of 0x200 (0xA2): issue, then ack next cycle, data held.
    vecs.push_back(mk(1,'h200, 0,0,0,    0,0,      1,0,'h200,0,    0,'h00, 0,'h00, 0));
    vecs.push_back(mk(1,'h200, 0,0,0,    0,0,      0,0,0,0,        1,'hA2, 0,'h00, 0));
    vecs.push_back(mk(0,0,     0,0,0,    0,0,      0,0,0,0,        0,'hA2, 0,'h00, 0));
    // Write 0x300=0x55 then read 0x300: write drains first, read sees 0x55.
    vecs.push_back(mk(0,0,     1,'h300,'h55, 0,0,  0,0,0,0,        0,'hA2, 0,'h00, 0));
    vecs.push_back(mk(1,'h300, 0,0,0,    0,0,      1,1,'h300,'h55, 0,'hA2, 0,'h00, 0));
    vecs.push_back(mk(1,'h300, 0,0,0,    0,0,      1,0,'h300,0,    0,'hA2, 0,'h00, 0));
    vecs.push_back(mk(1,'h300, 0,0,0,    0,0,      0,0,0,0,        1,'h55, 0,'h00, 0));
    vecs.push_back(mk(0,0,     0,0,0,    0,0,      0,0,0,0,        0,'h55, 0,'h00, 0));
    // Lone video read of 0x400 (0x11).
    vecs.push_back(mk(0,0,     0,0,0,    1,'h400,  1,0,'h400,0,    0,'h55, 0,'h00, 0));
    vecs.push_back(mk(0,0,     0,0,0,    1,'h400,  0,0,0,0,        0,'h55, 1,'h11, 0));
    vecs.push_back(mk(0,0,     0,0,0,    0,0,      0,0,0,0,        0,'h55, 0,'h11, 0));
    // Both held: CPU, CPU, CPU, VID, CPU ...
    vecs.push_back(mk(1,'h500, 0,0,0,    1,'h400,  1,0,'h500,0,    0,'h55, 0,'h11, 0));
    vecs.push_back(mk(1,'h500, 0,0,0,    1,'h400,  0,0,0,0,        1,'h22, 0,'h11, 0));
    vecs.push_back(mk(1,'h500, 0,0,0,    1,'h400,  1,0,'h500,0,    0,'h22, 0,'h11, 0));
    vecs.push_back(mk(1,'h500, 0,0,0,    1,'h400,  0,0,0,0,        1,'h22, 0,'h11, 0));
    vecs.push_back(mk(1,'h500, 0,0,0,    1,'h400,  1,0,'h500,0,    0,'h22, 0,'h11, 0));
    vecs.push_back(mk(1,'h500, 0,0,0,    1,'h400,  0,0,0,0,        1,'h22, 0,'h11, 0));
    vecs.push_back(mk(1,'h500, 0,0,0,    1,'h400,  1,0,'h400,0,    0,'h22, 0,'h11, 0));
    vecs.push_back(mk(1,'h500, 0,0,0,    1,'h400,  0,0,0,0,        0,'h22, 1,'h11, 0));
    vecs.push_back(mk(1,'h500, 0,0,0,    1,'h400,  1,0,'h500,0,    0,'h22, 0,'h11, 0));
    vecs.push_back(mk(1,'h500, 0,0,0,    1,'h400,  0,0,0,0,        1,'h22, 0,'h11, 0));
    vecs.push_back(mk(0,0,     0,0,0,    0,0,      0,0,0,0,        0,'h22, 0,'h11, 0));
    // Writes on two consecutive cycles, the second during CPU_RD: dropped.
    vecs.push_back(mk(1,'h200, 1,'h600,'h66, 0,0,  1,0,'h200,0,    0,'h22, 0,'h11, 0));
    vecs.push_back(mk(1,'h200, 1,'h700,'h77, 0,0,  0,0,0,0,        1,'hA2, 0,'h11, 0));
    vecs.push_back(mk(0,0,     0,0,0,    0,0,      1,1,'h600,'h66, 0,'hA2, 0,'h11, 1));
    vecs.push_back(mk(0,0,     0,0,0,    0,0,      0,0,0,0,        0,'hA2, 0,'h11, 1));
    vecs.push_back(mk(1,'h600, 0,0,0,    0,0,      1,0,'h600,0,    0,'hA2, 0,'h11, 1));
    vecs.push_back(mk(1,'h600, 0,0,0,    0,0,      0,0,0,0,        1,'h66, 0,'h11, 1));
    vecs.push_back(mk(1,'h700, 0,0,0,    0,0,      1,0,'h700,0,    0,'h66, 0,'h11, 1));
    vecs.push_back(mk(1,'h700, 0,0,0,    0,0,      0,0,0,0,        1,'h07, 0,'h11, 1));
    vecs.push_back(mk(0,0,     0,0,0,    0,0,      0,0,0,0,        0,'h07, 0,'h11, 1));
    // Write arriving while the buffer drains is accepted.
    vecs.push_back(mk(0,0,     1,'h800,'h88, 0,0,  0,0,0,0,        0,'h07, 0,'h11, 1));
    vecs.push_back(mk(0,0,     1,'h900,'h99, 0,0,  1,1,'h800,'h88, 0,'h07, 0,'h11, 1));
    vecs.push_back(mk(0,0,     0,0,0,    0,0,      1,1,'h900,'h99, 0,'h07, 0,'h11, 1));
    vecs.push_back(mk(0,0,     0,0,0,    0,0,      0,0,0,0,        0,'h07, 0,'h11, 1));

    // Reset state.
    repeat (2) @(negedge clk);
    #2;
    check_idle_outputs("reset", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      cpu_read       = vecs[i].crd;
      cpu_read_addr  = vecs[i].cra;
      cpu_write      = vecs[i].cwr;
      cpu_write_addr = vecs[i].cwa;
      cpu_write_data = vecs[i].cwd;
      vid_read       = vecs[i].vrd;
      vid_read_addr  = vecs[i].vra;
      #2;
      check($sformatf("v%0d_en", i), ram_en, vecs[i].en);
      check($sformatf("v%0d_we", i), ram_we, vecs[i].we);
      if (vecs[i].en) check($sformatf("v%0d_addr", i), ram_addr, vecs[i].addr);
      if (vecs[i].we) check($sformatf("v%0d_wdata", i), ram_wdata, vecs[i].wd);
      check($sformatf("v%0d_cack", i), cpu_read_ack, vecs[i].ca);
      check($sformatf("v%0d_cdata", i), cpu_read_data, vecs[i].cd);
      check($sformatf("v%0d_vack", i), vid_read_ack, vecs[i].va);
      check($sformatf("v%0d_vdata", i), vid_read_data, vecs[i].vd);
      check($sformatf("v%0d_ovf", i), wr_overflow, vecs[i].ovf);
      check($sformatf("v%0d_wp", i), wp_hit, 1'b0);
    end

    // Reset asserted while in VID_RD: ack vanishes at once, nothing resumes.
    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b0;
    vid_read = 1'b1; vid_read_addr = 12'h400;
    #2;
    check("rstvid_issue", ram_en, 1'b1);
    @(posedge clk);
    #2;
    check("rstvid_ack_before", vid_read_ack, 1'b1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rstvid_during", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    vid_read = 1'b0;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #2;
      check_idle_outputs("rstvid_after", 8'h00, 8'h00, 1'b0);
    end

    // Write to a low address: discarded with MEM_ARB_WP_EN, written otherwise.
    @(negedge clk);
    cpu_write = 1'b1; cpu_write_addr = 12'h050; cpu_write_data = 8'hFF;
    #2;
    check("wp_strobe_en", ram_en, 1'b0);
    @(negedge clk);
    cpu_write = 1'b0;
    #2;
`ifdef MEM_ARB_WP_EN
    check("wp_hit_pulse", wp_hit, 1'b1);
    check("wp_no_en", ram_en, 1'b0);
    check("wp_no_we", ram_we, 1'b0);
`else
    check("wp_hit_tied", wp_hit, 1'b0);
    check("wp_wr_en", ram_en, 1'b1);
    check("wp_wr_we", ram_we, 1'b1);
    check("wp_wr_addr", ram_addr, 12'h050);
    check("wp_wr_data", ram_wdata, 8'hFF);
`endif
    @(negedge clk);
    #2;
    check("wp_hit_end", wp_hit, 1'b0);
    check("wp_ovf", wr_overflow, 1'b0);
    @(negedge clk);
    cpu_read = 1'b1; cpu_read_addr = 12'h050;
    #2;
    check("wp_rd_en", ram_en, 1'b1);
    check("wp_rd_addr", ram_addr, 12'h050);
    @(negedge clk);
    #2;
    check("wp_rd_ack", cpu_read_ack, 1'b1);
`ifdef MEM_ARB_WP_EN
    check("wp_rd_data", cpu_read_data, 8'h33);
`else
    check("wp_rd_data", cpu_read_data, 8'hFF);
`endif
    @(negedge clk);
    cpu_read = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter VID_MAX_WAIT, default 3: the number of consecutive arbitration losses a pending video read tolerates before it is forced to win.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_read  in  1  CPU read request; level, held until acked.
- cpu_read_addr  in  12  CPU read address.
- cpu_read_data  out  8  CPU read data; valid when cpu_read_ack=1.
- cpu_read_ack  out  1  one-cycle pulse, read complete.
- cpu_write  in  1  CPU write strobe; one-cycle pulse, no ack.
- cpu_write_addr  in  12  CPU write address.
- cpu_write_data  in  8  CPU write data.
- vid_read  in  1  video read request; level, held until acked.
- vid_read_addr  in  12  video read address.
- vid_read_data  out  8  video read data; valid when vid_read_ack=1.
- vid_read_ack  out  1  one-cycle pulse, read complete.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable; qualified by ram_en.
- ram_addr  out  12  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid the cycle after ram_en=1, ram_we=0.
- wr_overflow  out  1  sticky: a CPU write was dropped.
- wp_hit  out  1  one-cycle pulse: a protected write was discarded.

Function
REQ-003 SHALL implement FSM states IDLE, CPU_RD, VID_RD; only IDLE issues RAM accesses.
REQ-004 SHALL capture cpu_write into a 1-entry write buffer (addr, data, valid) in any state; the buffer is written in the same edge as the strobe.
REQ-005 IDLE priority: buffered write > cpu_read > vid_read.
- Exception: vid_read wins over cpu_read when the starvation counter equals VID_MAX_WAIT.
REQ-006 Buffered write in IDLE SHALL drive ram_en=1, ram_we=1 for one cycle, clear valid, and stay in IDLE; reads wait for the next IDLE cycle.
REQ-007 A granted read SHALL drive ram_en=1, ram_we=0, ram_addr=requester address for one cycle, then move to CPU_RD or VID_RD.
REQ-008 CPU_RD/VID_RD SHALL register ram_rdata into that requester's data output, pulse its ack for exactly one cycle, and return to IDLE.
- Read latency: request sampled in IDLE at cycle N, ack in N+1.
- Peak read throughput: one read per 2 cycles.
REQ-009 A read request still high in the cycle after its ack SHALL be treated as a new request.
REQ-010 cpu_read_data and vid_read_data SHALL hold their last value until the next ack of the same requester.
REQ-011 Starvation counter (width clog2(VID_MAX_WAIT+1)):
- Increments each IDLE cycle in which vid_read=1 but another access is granted.
- Saturates at VID_MAX_WAIT.
- Clears when a video read is granted or vid_read=0.
REQ-012 Write arriving with buffer valid and not draining that cycle SHALL be dropped and set wr_overflow (sticky until reset); a write arriving in the same cycle the buffer drains SHALL be accepted.
REQ-013 Read-after-write: a CPU read to an address with a buffered write SHALL return the new data, guaranteed by REQ-005 ordering.
REQ-014 RAM outputs SHALL be ram_en=0, ram_we=0 whenever no access is issued; ram_addr/ram_wdata are don't-care then.

Reset
REQ-015 rst=1 SHALL immediately:
- force state IDLE;
- clear buffer valid, starvation counter, wr_overflow, wp_hit, both acks, ram_en and ram_we;
- zero both read data outputs.
REQ-016 A read in flight at reset SHALL be abandoned without ack; requesters re-request after reset.

Configuration
REQ-017 Macro MEM_ARB_WP_EN defined: a cpu_write with address < 0x200 SHALL NOT enter the buffer, SHALL NOT affect wr_overflow, and SHALL pulse wp_hit for one cycle.
REQ-018 Macro MEM_ARB_WP_EN undefined: all addresses are writable and wp_hit is tied 0.

Verification
REQ-019 cpu_read addr 0x200, RAM[0x200]=0xA2 -> ram_en at N, cpu_read_ack=1 with data 0xA2 at N+1.
REQ-020 cpu_read and vid_read both held continuously, VID_MAX_WAIT=3 -> grant pattern CPU,CPU,CPU,VID repeating.
REQ-021 cpu_write 0x300=0x55 then cpu_read 0x300 next cycle -> RAM write first, read returns 0x55.
REQ-022 cpu_write pulses on two consecutive cycles while in CPU_RD -> second write dropped, wr_overflow=1 and stays 1.
REQ-023 MEM_ARB_WP_EN defined, cpu_write 0x050=0xFF -> no ram_we, wp_hit pulse, RAM[0x050] unchanged; undefined -> written.
REQ-024 rst asserted in VID_RD -> no vid_read_ack, state IDLE, all outputs at reset values.
